// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr_gen pseudo-random generator.
package lfsr_pkg;

  // Output slot occupancy.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  // Standard maximal-length Fibonacci tap masks.
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_if.sv
// Seed-load and output-stream signals of lfsr_gen.
// slave: the generator side; master: the seed source / consumer side.
interface lfsr_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = 1
) ();
  logic             seed_valid;
  logic [WIDTH-1:0] seed;
  logic             seed_ready;
  logic             en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [WIDTH-1:0] state;
  logic             wrap;
  logic             lockup;

  modport slave (
    input  seed_valid, seed, en, out_ready,
    output seed_ready, out_valid, out_data, state, wrap, lockup
  );

  modport master (
    output seed_valid, seed, en, out_ready,
    input  seed_ready, out_valid, out_data, state, wrap, lockup
  );
endinterface

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR step: shift left, feedback into bit 0,
// emitted bit is the MSB before the shift.
module lfsr_step #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
  parameter bit               INV_OUT = 1'b0
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o,
  output logic             bit_o
);

  // Single step of the shift register and its output bit.
  always_comb begin
    next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
    bit_o  = state_i[WIDTH-1] ^ INV_OUT;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR generator with valid/ready output stream,
// seed-load handshake, wrap detection and optional all-zero recovery.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (zero state -> DEFAULT_SEED).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W8,
  parameter int unsigned      OUT_W        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit               INV_OUT      = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  lfsr_if.slave bus
);

  slot_e                      slot_q, slot_d;
  logic [WIDTH-1:0]           state_q, state_d;
  logic [WIDTH-1:0]           ref_q, ref_d;
  logic [OUT_W-1:0]           data_q, data_d;
  logic                       wrap_q, wrap_d;
  logic [WIDTH-1:0]           seed_ld;
  logic                       slot_free;
  logic [OUT_W-1:0]           bits_w;
  logic [OUT_W-1:0]           hit_w;
  logic [OUT_W:0][WIDTH-1:0]  chain;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic [OUT_W-1:0]           zero_w;
  logic                       seed_zero;
  logic                       lockup_q, lockup_d;
`endif

  assign chain[0] = state_q;

  // OUT_W unrolled steps; each intermediate state is compared with the wrap
  // reference and, when recovery is built in, forced off zero.
  for (genvar k = 0; k < OUT_W; k++) begin : g_step
    logic [WIDTH-1:0] raw;

    lfsr_step #(
      .WIDTH   (WIDTH),
      .TAPS    (TAPS),
      .INV_OUT (INV_OUT)
    ) u_step (
      .state_i (chain[k]),
      .next_o  (raw),
      .bit_o   (bits_w[k])
    );

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign zero_w[k]   = (raw == '0);
    assign chain[k+1]  = zero_w[k] ? DEFAULT_SEED : raw;
`else
    assign chain[k+1]  = raw;
`endif
    assign hit_w[k]    = (chain[k+1] == ref_q);
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign seed_zero = (bus.seed == '0);
  assign seed_ld   = seed_zero ? DEFAULT_SEED : bus.seed;
`else
  assign seed_ld   = bus.seed;
`endif

  assign slot_free = (slot_q == S_EMPTY) || bus.out_ready;

  // Next-state: seed load beats generation; otherwise fill or drain the slot.
  always_comb begin
    slot_d   = slot_q;
    state_d  = state_q;
    ref_d    = ref_q;
    data_d   = data_q;
    wrap_d   = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    lockup_d = 1'b0;
`endif
    if (bus.seed_valid && slot_free) begin
      state_d  = seed_ld;
      ref_d    = seed_ld;
      slot_d   = S_EMPTY;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_d = seed_zero;
`endif
    end else if (slot_free) begin
      if (bus.en) begin
        data_d   = bits_w;
        state_d  = chain[OUT_W];
        slot_d   = S_FULL;
        wrap_d   = |hit_w;
`ifdef LFSR_LOCKUP_RECOVER_EN
        lockup_d = |zero_w;
`endif
      end else begin
        slot_d = S_EMPTY;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= S_EMPTY;
      state_q  <= DEFAULT_SEED;
      ref_q    <= DEFAULT_SEED;
      data_q   <= '0;
      wrap_q   <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      slot_q   <= slot_d;
      state_q  <= state_d;
      ref_q    <= ref_d;
      data_q   <= data_d;
      wrap_q   <= wrap_d;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_q <= lockup_d;
`endif
    end
  end

  assign bus.seed_ready = slot_free;
  assign bus.out_valid  = (slot_q == S_FULL);
  assign bus.out_data   = data_q;
  assign bus.state      = state_q;
  assign bus.wrap       = wrap_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
  assign bus.lockup     = lockup_q;
`else
  assign bus.lockup     = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: three configurations driven by one
// shared stimulus, checked by directed tables and a word-level model.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  localparam int NDUT = 3;
  localparam int unsigned CW   [NDUT] = '{8, 8, 16};
  localparam int unsigned COW  [NDUT] = '{1, 8, 5};
  localparam logic [31:0] CTP  [NDUT] = '{32'h0000_00B8, 32'h0000_00B8, 32'h0000_B400};
  localparam logic [31:0] CDS  [NDUT] = '{32'h1, 32'h1, 32'hACE1};
  localparam bit          CINV [NDUT] = '{1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic        sv, en, rdy;
  logic [31:0] sd;

  always #5 clk = ~clk;

  lfsr_if #(.WIDTH(8),  .OUT_W(1)) ifa ();
  lfsr_if #(.WIDTH(8),  .OUT_W(8)) ifb ();
  lfsr_if #(.WIDTH(16), .OUT_W(5)) ifc ();

  assign ifa.seed_valid = sv;  assign ifa.seed = sd[7:0];  assign ifa.en = en;  assign ifa.out_ready = rdy;
  assign ifb.seed_valid = sv;  assign ifb.seed = sd[7:0];  assign ifb.en = en;  assign ifb.out_ready = rdy;
  assign ifc.seed_valid = sv;  assign ifc.seed = sd[15:0]; assign ifc.en = en;  assign ifc.out_ready = rdy;

  lfsr_gen #(.WIDTH(8), .TAPS(TAPS_W8), .OUT_W(1), .DEFAULT_SEED(8'h01), .INV_OUT(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  lfsr_gen #(.WIDTH(8), .TAPS(TAPS_W8), .OUT_W(8), .DEFAULT_SEED(8'h01), .INV_OUT(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  lfsr_gen #(.WIDTH(16), .TAPS(TAPS_W16), .OUT_W(5), .DEFAULT_SEED(16'hACE1), .INV_OUT(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic [31:0] o_data  [NDUT];
  logic [31:0] o_state [NDUT];
  logic        o_valid [NDUT];
  logic        o_sready[NDUT];
  logic        o_wrap  [NDUT];
  logic        o_lock  [NDUT];

  assign o_data[0]  = 32'(ifa.out_data);  assign o_data[1]  = 32'(ifb.out_data);  assign o_data[2]  = 32'(ifc.out_data);
  assign o_state[0] = 32'(ifa.state);     assign o_state[1] = 32'(ifb.state);     assign o_state[2] = 32'(ifc.state);
  assign o_valid[0] = ifa.out_valid;      assign o_valid[1] = ifb.out_valid;      assign o_valid[2] = ifc.out_valid;
  assign o_sready[0]= ifa.seed_ready;     assign o_sready[1]= ifb.seed_ready;     assign o_sready[2]= ifc.seed_ready;
  assign o_wrap[0]  = ifa.wrap;           assign o_wrap[1]  = ifb.wrap;           assign o_wrap[2]  = ifc.wrap;
  assign o_lock[0]  = ifa.lockup;         assign o_lock[1]  = ifb.lockup;         assign o_lock[2]  = ifc.lockup;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word level) ----------------
  typedef struct {
    logic [31:0] nxt;
    logic [31:0] word;
    logic        wrap;
    logic        zero;
  } mres_t;

  function automatic logic [31:0] mask_of(input int d);
    return (CW[d] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << CW[d]) - 32'h1);
  endfunction

  function automatic logic [31:0] recov(input int d, input logic [31:0] s);
`ifdef LFSR_LOCKUP_RECOVER_EN
    return (s == 32'h0) ? CDS[d] : s;
`else
    return s + 32'h0 * 32'(d);
`endif
  endfunction

  function automatic mres_t mword(input int d, input logic [31:0] s0, input logic [31:0] rf);
    mres_t       r;
    logic [31:0] s;
    logic        fb;
    s      = s0;
    r.word = 32'h0;
    r.wrap = 1'b0;
    r.zero = 1'b0;
    for (int unsigned k = 0; k < COW[d]; k++) begin
      r.word[k] = s[CW[d]-1] ^ CINV[d];
      fb = ($countones(s & CTP[d]) % 2) == 1;
      s  = ((s << 1) | {31'b0, fb}) & mask_of(d);
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (s == 32'h0) begin
        s      = CDS[d];
        r.zero = 1'b1;
      end
`endif
      if (s == rf) r.wrap = 1'b1;
    end
    r.nxt = s;
    return r;
  endfunction

  logic [31:0] m_state [NDUT];
  logic [31:0] m_ref   [NDUT];
  logic [31:0] p_data  [NDUT];
  logic        p_valid [NDUT];
  logic        p_seedhs[NDUT];
  logic        p_seed0 [NDUT];
  logic        p_rdy;

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_state[d]  = CDS[d];
      m_ref[d]    = CDS[d];
      p_data[d]   = 32'h0;
      p_valid[d]  = 1'b0;
      p_seedhs[d] = 1'b0;
      p_seed0[d]  = 1'b0;
    end
    p_rdy = 1'b0;
  endtask

  // Called once per cycle with this cycle's inputs applied, before the edge.
  task automatic monitor();
    for (int d = 0; d < NDUT; d++) begin
      mres_t       r;
      logic        newword;
      logic        explock;
      logic [31:0] sdm;
      r       = mword(d, m_state[d], m_ref[d]);
      newword = o_valid[d] && !(p_valid[d] && !p_rdy);
      explock = 1'b0;
      sdm     = sd & mask_of(d);
      chk("seed_ready", d, 32'(o_sready[d]), 32'(!o_valid[d] || rdy));
      if (p_valid[d] && !p_rdy) chk("valid_hold", d, 32'(o_valid[d]), 32'h1);
      if (o_valid[d]) begin
        chk("state_busy", d, o_state[d], r.nxt);
        if (newword) begin
          chk("wrap_new", d, 32'(o_wrap[d]), 32'(r.wrap));
`ifdef LFSR_LOCKUP_RECOVER_EN
          explock = r.zero;
`endif
        end else begin
          chk("data_hold", d, o_data[d], p_data[d]);
          chk("wrap_hold", d, 32'(o_wrap[d]), 32'h0);
        end
      end else begin
        chk("state_idle", d, o_state[d], m_state[d]);
        chk("wrap_idle", d, 32'(o_wrap[d]), 32'h0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        explock = p_seedhs[d] && p_seed0[d];
`endif
      end
      chk("lockup", d, 32'(o_lock[d]), 32'(explock));
      p_seedhs[d] = 1'b0;
      if (o_valid[d] && rdy) begin
        chk("word", d, o_data[d], r.word);
        m_state[d] = r.nxt;
      end
      if (sv && o_sready[d]) begin
        m_state[d]  = recov(d, sdm);
        m_ref[d]    = recov(d, sdm);
        p_seedhs[d] = 1'b1;
        p_seed0[d]  = (sdm == 32'h0);
      end
      p_valid[d] = o_valid[d];
      p_data[d]  = o_data[d];
    end
    p_rdy = rdy;
  endtask

  // Inputs are set at posedge+1; monitor at posedge+2; return at next posedge+1.
  task automatic cycle();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sv  = 1'b0; en = 1'b0; rdy = 1'b0; sd = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       bit_a;
    logic [7:0] st_a;
    logic       chk_b;
    logic [7:0] word_b;
    logic [7:0] st_b;
  } vec_t;

  vec_t        tab [8];
  logic [31:0] rec_d [NDUT];
  logic [31:0] rec_s [NDUT];
  logic [31:0] expw;
  logic        bw;

  initial begin
    // seed 0x01: single-bit stream (dut_a) and 8-bit words (dut_b)
    tab[0] = '{1'b0, 8'h02, 1'b1, 8'h80, 8'h1C};
    tab[1] = '{1'b0, 8'h04, 1'b1, 8'h38, 8'h4B};
    tab[2] = '{1'b0, 8'h08, 1'b0, 8'h00, 8'h00};
    tab[3] = '{1'b0, 8'h11, 1'b0, 8'h00, 8'h00};
    tab[4] = '{1'b0, 8'h23, 1'b0, 8'h00, 8'h00};
    tab[5] = '{1'b0, 8'h47, 1'b0, 8'h00, 8'h00};
    tab[6] = '{1'b0, 8'h8E, 1'b0, 8'h00, 8'h00};
    tab[7] = '{1'b1, 8'h1C, 1'b0, 8'h00, 8'h00};

    do_reset();
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_state", d, o_state[d], CDS[d]);
      chk("rst_valid", d, 32'(o_valid[d]), 32'h0);
      chk("rst_data",  d, o_data[d], 32'h0);
      chk("rst_wrap",  d, 32'(o_wrap[d]), 32'h0);
      chk("rst_lock",  d, 32'(o_lock[d]), 32'h0);
    end

    // Seed 0x01 then free-running stream
    sv = 1'b1; sd = 32'h1; en = 1'b1; rdy = 1'b1;
    cycle();
    sv = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk("seed_valid_t1", d, 32'(o_valid[d]), 32'h0);
      chk("seed_state_t1", d, o_state[d], 32'h1);
    end
    cycle();
    for (int i = 0; i < 8; i++) begin
      chk("tab_valid", 0, 32'(o_valid[0]), 32'h1);
      chk("tab_bit",   0, o_data[0], 32'(tab[i].bit_a));
      chk("tab_state", 0, o_state[0], 32'(tab[i].st_a));
      if (tab[i].chk_b) begin
        chk("tab_word",   1, o_data[1], 32'(tab[i].word_b));
        chk("tab_stateb", 1, o_state[1], 32'(tab[i].st_b));
      end
      cycle();
    end

    // Wrap: period 255 single-bit steps from the loaded seed
    for (int idx = 8; idx < 260; idx++) begin
      chk("wrap_a", 0, 32'(o_wrap[0]), 32'(((idx + 1) % 255) == 0));
      bw = 1'b0;
      for (int n = 8 * idx + 1; n <= 8 * idx + 8; n++) if ((n % 255) == 0) bw = 1'b1;
      chk("wrap_b", 1, 32'(o_wrap[1]), 32'(bw));
      cycle();
    end

    // Stall 5 cycles, seed offered during the stall is held off
    rdy = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      rec_d[d] = o_data[d];
      rec_s[d] = o_state[d];
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin sv = 1'b1; sd = 32'hA5; end
      cycle();
      for (int d = 0; d < NDUT; d++) begin
        chk("stall_valid", d, 32'(o_valid[d]), 32'h1);
        chk("stall_data",  d, o_data[d], rec_d[d]);
        chk("stall_state", d, o_state[d], rec_s[d]);
        chk("stall_sready", d, 32'(o_sready[d]), 32'h0);
      end
    end
    rdy = 1'b1;
    cycle();
    sv = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk("accseed_valid", d, 32'(o_valid[d]), 32'h0);
      chk("accseed_state", d, o_state[d], 32'hA5);
    end
    cycle();
    chk("a5_valid", 0, 32'(o_valid[0]), 32'h1);
    chk("a5_bit",   0, o_data[0], 32'h1);
    chk("a5_state", 0, o_state[0], 32'h4A);
    expw = mword(1, 32'hA5, 32'hA5).word;
    chk("a5_word",  1, o_data[1], expw);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("amid_valid", d, 32'(o_valid[d]), 32'h0);
      chk("amid_data",  d, o_data[d], 32'h0);
      chk("amid_state", d, o_state[d], CDS[d]);
    end
    model_reset();
    en = 1'b0; rdy = 1'b0; sv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    cycle();
    chk("post_rst_valid", 0, 32'(o_valid[0]), 32'h1);
    sv = 1'b1; sd = 32'hA5; rdy = 1'b1;
    cycle();
    sv = 1'b0;
    chk("rseed_valid_t1", 0, 32'(o_valid[0]), 32'h0);
    chk("rseed_state_t1", 0, o_state[0], 32'hA5);
    cycle();
    chk("rseed_valid_t2", 0, 32'(o_valid[0]), 32'h1);
    chk("rseed_bit_t2",   0, o_data[0], 32'h1);
    chk("rseed_state_t2", 0, o_state[0], 32'h4A);

    // Zero seed
    sv = 1'b1; sd = 32'h0;
    cycle();
    sv = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    for (int d = 0; d < NDUT; d++) begin
      chk("zseed_state", d, o_state[d], CDS[d]);
      chk("zseed_lock",  d, 32'(o_lock[d]), 32'h1);
    end
    cycle();
    for (int d = 0; d < NDUT; d++) chk("zseed_lock_end", d, 32'(o_lock[d]), 32'h0);
`else
    for (int d = 0; d < NDUT; d++) begin
      chk("zseed_state", d, o_state[d], 32'h0);
      chk("zseed_lock",  d, 32'(o_lock[d]), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int d = 0; d < NDUT; d++) begin
        chk("zero_valid", d, 32'(o_valid[d]), 32'h1);
        chk("zero_data",  d, o_data[d], CINV[d] ? ((32'h1 << COW[d]) - 32'h1) : 32'h0);
        chk("zero_state", d, o_state[d], 32'h0);
      end
    end
`endif

    // Randomized traffic against the word-level model
    for (int n = 0; n < 2000; n++) begin
      sv  = ($urandom % 8) == 0;
      sd  = (($urandom % 16) == 0) ? 32'h0 : $urandom;
      en  = ($urandom % 4) != 0;
      rdy = ($urandom % 4) != 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random generator, successor to the fixed 8-bit single-bit generator. It supports arbitrary width and tap mask, emits OUT_W bits per cycle over a valid/ready stream, and accepts seed loads over a handshake. It also reports sequence wrap and handles all-zero lockup. It sits between the seed/config logic and the consumers of test-pattern or scrambler bits.

## Interface
- WIDTH, 8: LFSR register width; legal range 3..32.
- TAPS, 8'hB8: feedback mask; bit i set means state[i] is XORed into feedback.
- OUT_W, 1: bits emitted per accepted word; legal range 1..WIDTH.
- DEFAULT_SEED, 1: state after reset, and recovery value; must be non-zero.
- INV_OUT, 0: when 1, every emitted bit is inverted.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_valid  in  1  seed offered.
- seed  in  WIDTH  seed value.
- seed_ready  out  1  seed accepted when seed_valid and seed_ready are both high.
- en  in  1  allows generation of new words.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_W  generated bits; bit 0 is the oldest.
- state  out  WIDTH  current LFSR register.
- wrap  out  1  one-cycle pulse: the sequence returned to the last loaded seed.
- lockup  out  1  one-cycle pulse: an all-zero recovery happened.

## Operation
- Single step:
  - fb = XOR-reduce(state & TAPS).
  - next state = {state[WIDTH-2:0], fb}.
  - emitted bit = state[WIDTH-1] ^ INV_OUT, taken before the step.
- A generated word advances the state by OUT_W unrolled steps in one cycle. out_data[k] is the bit emitted at step k.
- Output slot is free when out_valid=0 or out_ready=1. With en=1 and the slot free:
  - out_data is loaded.
  - state advances by OUT_W steps.
  - out_valid is set to 1.
- With en=0 and out_ready=1, out_valid clears.
- While out_valid=1 and out_ready=0, out_data and state hold. out_valid never drops without a handshake.
- seed_ready = ~out_valid | out_ready (combinational).
- On seed handshake:
  - state is loaded with seed, and seed is also captured as the wrap reference.
  - out_valid is cleared, and no word is generated that cycle. A seed load has priority over generation.
- Simultaneous seed load and output accept: the word is consumed and the seed is loaded. The next word is generated from the seed on the following cycle.
- wrap pulses in the cycle after any of the OUT_W intermediate states of a generated word equals the wrap reference.
- Reset:
  - state = DEFAULT_SEED, wrap reference = DEFAULT_SEED.
  - out_valid=0, out_data=0, wrap=0, lockup=0.
- Reset mid-stream discards the pending word immediately (asynchronous).

## Timing
- Seed handshake at cycle t with en=1: out_valid=1 at t+2, with the first word derived from the seed.
- Steady state: one word per cycle while en=1 and out_ready=1.
- wrap and lockup are registered and coincide with the out_valid edge of the word that caused them.
- No combinational path from out_ready to out_data. seed_ready is the only combinational output.

## Configuration
- LFSR_LOCKUP_RECOVER_EN defined:
  - A zero seed load, or a zero intermediate state, is replaced by DEFAULT_SEED.
  - lockup pulses for one cycle.
  - Generation continues from DEFAULT_SEED.
- LFSR_LOCKUP_RECOVER_EN undefined:
  - A zero state is kept, and the output stays constant at INV_OUT.
  - lockup is tied to 0.

## Structure
- Shared package lfsr_pkg holds:
  - the state-encoding typedef for the output slot (S_EMPTY, S_FULL);
  - the standard maximal tap constants: 8'hB8 for width 8, 16'hB400 for width 16, 32'h8020_0003 for width 32.
- One sub-module, lfsr_step, is natural: combinational, WIDTH/TAPS-parametrised, one step, producing next state and emitted bit. It is instantiated OUT_W times in a chain.

## Test plan
- Reset with DEFAULT_SEED=1 -> state=0x01, out_valid=0, wrap=0, lockup=0.
- WIDTH=8, OUT_W=1, seed 0x01 loaded, en=1, out_ready=1 -> first 8 bits 0,0,0,0,0,0,0,1; state after 8 words = 0x1C.
- Same seed, OUT_W=8 -> first word 0x80, state 0x1C; wrap pulses after 255 single-bit steps (verified with OUT_W=1, word 255).
- out_ready held low 5 cycles with out_valid=1 -> out_data and state unchanged, seed_ready=0; a seed offered during the stall is held off until the accept.
- Seed 0x00 with LFSR_LOCKUP_RECOVER_EN defined -> state becomes DEFAULT_SEED, lockup pulses once. Without the macro -> state 0x00 and all output bits equal INV_OUT.
- rst asserted mid-stream while out_valid=1 -> out_valid=0 immediately. After release, seed 0xA5 plus out accept in the same cycle -> next word derived from 0xA5 at t+2.
